branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped table of 2-bit saturating counters with a tagged branch target buffer.
- Fetch issues a PC lookup and receives a taken/target prediction one cycle later.
- Execute returns each branch's resolved outcome (the comparator's taken decision and the computed target). The block trains on it and raises a registered mispredict/redirect toward fetch.
- Forms the prediction-and-flush end of the branch-resolution path.

Parameters:
- IDX_BITS, 6, table index width; 2^IDX_BITS entries.
- TAG_BITS, 8, tag width stored per entry.
- XLEN, 32, PC/target width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- ready  output  1  table initialised; predictions valid
- pred_valid  input  1  lookup request this cycle
- pred_pc  input  XLEN  PC to look up
- pred_resp_valid  output  1  prediction response valid
- pred_taken  output  1  predicted taken
- pred_target  output  XLEN  predicted next PC
- res_valid  input  1  branch resolution this cycle
- res_pc  input  XLEN  PC of the resolved branch
- res_taken  input  1  actual outcome from the comparator
- res_target  input  XLEN  actual branch target
- res_pred_taken  input  1  prediction originally made for this branch
- res_pred_target  input  XLEN  target originally predicted
- mispredict  output  1  one-cycle flush pulse
- redirect_pc  output  XLEN  correct next PC when mispredict=1
- stat_branches  output  32  resolved branch count (optional feature)
- stat_mispredicts  output  32  misprediction count (optional feature)

Behaviour:

Reset and clocking:
- Single clock domain; reset is synchronous and active-high and dominates all other inputs.
- Reset values: ready=0, pred_resp_valid=0, pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0, stat counters=0, FSM=INIT, sweep index=0.

Address fields:
- idx = pc[IDX_BITS+1:2].
- tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- pc_plus4 wraps modulo 2^XLEN.

FSM:
- INIT: writes entry[sweep] = {valid=0, ctr=2'b01, tag=0, target=0} and increments sweep each cycle. After writing entry 2^IDX_BITS-1, goes to RUN; ready=1 from the next cycle. INIT therefore lasts exactly 2^IDX_BITS cycles.
- RUN: normal operation; leaves RUN only on reset.
- Reset asserted mid-operation (in either state) restarts INIT from sweep=0 on the following cycle.

Lookup (1-cycle latency):
- pred_valid at cycle N gives pred_resp_valid=1 at N+1; pred_resp_valid=0 when pred_valid was 0.
- hit = valid && stored tag == tag(pred_pc).
- pred_taken = ready && hit && ctr[1].
- pred_target = pred_taken ? stored target : pred_pc+4.
- During INIT, responses are still produced with pred_taken=0 and pred_target=pc+4.

Training (RUN only; ignored during INIT):
- Entry hit: ctr increments when res_taken=1, saturating at 3; decrements when res_taken=0, saturating at 0.
- Entry hit and res_taken=1: target is rewritten with res_target.
- Entry miss and res_taken=1: allocate/overwrite with valid=1, tag, target=res_target, ctr=2'b10.
- Entry miss and res_taken=0: no write.
- Lookup and training to the same idx in the same cycle: the lookup returns the pre-update contents (read-before-write).

Mispredict (registered, 1 cycle after res_valid, independent of FSM state):
- mispredict = (res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target).
- redirect_pc = res_taken ? res_target : res_pc+4.
- Both hold 0 / previous value rules: mispredict=0 in any cycle not following a res_valid. redirect_pc holds its last value when mispredict=0.
- Back-to-back res_valid produces back-to-back independent pulses.

Optional Feature:
- BP_STATS_EN defined:
  - stat_branches increments on every res_valid.
  - stat_mispredicts increments whenever the mispredict condition is true for that resolution.
  - Both counters count in INIT and RUN, wrap at 2^32, and clear on reset.
- Macro undefined: both ports remain present and are driven constant 0; no counter logic is instantiated.

Test Plan:
- Reset, then idle (IDX_BITS=6) -> ready=0 for exactly 64 cycles, rises on cycle 65; pred_valid during INIT with pc=0x100 -> next cycle pred_resp_valid=1, pred_taken=0, pred_target=0x104.
- After ready: res_valid pc=0x200, taken=1, target=0x180, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x180; then lookup 0x200 -> pred_taken=1, pred_target=0x180.
- Counter saturation on pc=0x200: four taken resolutions, then one not-taken -> still predicted taken (ctr 3->2); a second not-taken -> pred_taken=0, pred_target=0x204.
- Tag alias: train pc=0x200 taken; lookup pc=0x200+(1<<8) (same idx, different tag) -> pred_taken=0; a not-taken resolution at that alias leaves 0x200's entry intact.
- Same-cycle lookup and training at idx of 0x300 (ctr=1, taken) -> lookup returns taken=0; the lookup one cycle later returns taken=1. Reset asserted mid-RUN -> ready drops next cycle and table cleared (0x200 then predicts not-taken).
- BP_STATS_EN: 10 resolutions, 3 mispredicted -> stat_branches=10, stat_mispredicts=3; without macro both read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counters with a tagged BTB and registered redirect.
// Define BP_STATS_EN to build the resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic            pred_valid,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_resp_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);
    localparam int unsigned Entries = 1 << IDX_BITS;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e              state_q;
    logic [IDX_BITS-1:0] sweep_q;
    logic                ready_q;
    logic                resp_valid_q;
    logic                taken_q;
    logic [XLEN-1:0]     target_q;
    logic                mis_q;
    logic [XLEN-1:0]     redirect_q;

    logic                valid_q [Entries];
    logic [1:0]          ctr_q   [Entries];
    logic [TAG_BITS-1:0] tag_q   [Entries];
    logic [XLEN-1:0]     btb_q   [Entries];

    logic [IDX_BITS-1:0] lk_idx, rs_idx;
    logic [TAG_BITS-1:0] lk_tag, rs_tag;
    logic                lk_hit, lk_taken, rs_hit, rs_mis;
    logic [XLEN-1:0]     lk_target, rs_redirect;

    always_comb begin
        lk_idx      = pred_pc[IDX_BITS+1:2];
        lk_tag      = pred_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        rs_idx      = res_pc[IDX_BITS+1:2];
        rs_tag      = res_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken    = ready_q && lk_hit && ctr_q[lk_idx][1];
        lk_target   = lk_taken ? btb_q[lk_idx] : pred_pc + XLEN'(4);
        rs_hit      = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
        rs_mis      = (res_taken != res_pred_taken)
                   || (res_taken && (res_target != res_pred_target));
        rs_redirect = res_taken ? res_target : res_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            sweep_q      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            mis_q        <= 1'b0;
            redirect_q   <= '0;
        end else begin
            case (state_q)
                StInit: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (&sweep_q) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun:   state_q <= StRun;
                default: state_q <= StInit;
            endcase
            resp_valid_q <= pred_valid;
            taken_q      <= lk_taken;
            target_q     <= lk_target;
            mis_q        <= res_valid && rs_mis;
            if (res_valid && rs_mis) begin
                redirect_q <= rs_redirect;
            end
        end
    end

    // Table storage is cleared by the INIT sweep rather than by reset itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StInit) begin
                valid_q[sweep_q] <= 1'b0;
                ctr_q[sweep_q]   <= 2'b01;
                tag_q[sweep_q]   <= '0;
                btb_q[sweep_q]   <= '0;
            end else if (res_valid) begin
                if (rs_hit) begin
                    if (res_taken) begin
                        btb_q[rs_idx] <= res_target;
                        if (ctr_q[rs_idx] != 2'b11) begin
                            ctr_q[rs_idx] <= ctr_q[rs_idx] + 2'd1;
                        end
                    end else if (ctr_q[rs_idx] != 2'b00) begin
                        ctr_q[rs_idx] <= ctr_q[rs_idx] - 2'd1;
                    end
                end else if (res_taken) begin
                    valid_q[rs_idx] <= 1'b1;
                    tag_q[rs_idx]   <= rs_tag;
                    btb_q[rs_idx]   <= res_target;
                    ctr_q[rs_idx]   <= 2'b10;
                end
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (res_valid) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (rs_mis) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    assign ready           = ready_q;
    assign pred_resp_valid = resp_valid_q;
    assign pred_taken      = taken_q;
    assign pred_target     = target_q;
    assign mispredict      = mis_q;
    assign redirect_pc     = redirect_q;

endmodule
